switch_code_capture: RTL
========================

// Module: switch_code_capture
// PURPOSE
//  Parametrised switch front-end. Synchronises SW_N raw slide switches and classifies each
//  cycle's change as UP/DOWN/UNCHANGE. Captures the index of each switch that goes 0->1 as
//  one digit of a CODE_DEPTH-digit entry code.
//  Sits between the board switch pins and the code-compare/display logic.
// PARAMETERS
//  SW_N        10  number of switch inputs (2..16)
//  CODE_DEPTH   4  digits per code (1..8)
//  DIGIT_W      4  bits per digit; must be >= $clog2(SW_N)
//  DEB_CYCLES  16  debounce stable-count; used only with SWITCH_DEBOUNCE_EN
// PORTS
//  CLK        in   1                    system clock, rising edge
//  RST_N      in   1                    async active-low reset
//  SW         in   SW_N                 raw asynchronous switch levels
//  CLR        in   1                    sync clear: empties code, clears flags
//  SW_State   out  SW_N                 registered (filtered) switch history
//  Evt        out  2                    last-cycle event: UP=1, DOWN=0, UNCHANGE=2
//  Evt_Idx    out  DIGIT_W              index of switch causing Evt (0 if UNCHANGE)
//  Code       out  CODE_DEPTH*DIGIT_W   captured digits; newest in LSB digit
//  Code_Cnt   out  $clog2(CODE_DEPTH+1) digits held (saturates at CODE_DEPTH)
//  Code_Full  out  1                    Code_Cnt == CODE_DEPTH
//  Code_Vld   out  1                    1-cycle pulse when Code_Cnt becomes CODE_DEPTH
//  Multi_Err  out  1                    sticky: >1 rising edge in one cycle
// BEHAVIOUR
//  - Reset: all outputs/regs 0, Evt=UNCHANGE. Sync chain and history cleared.
//  - Arm: edge detection suppressed 3 cycles after RST_N rises. History tracks synced value
//    meanwhile; switches already high at reset release generate no event.
//  - Sync: 2-flop per bit. rise = sync & ~hist; fall = ~sync & hist; hist <= sync each cycle.
//  - Classify: any rise -> Evt=UP, Evt_Idx = lowest rising index.
//    Else any fall -> Evt=DOWN, Evt_Idx = lowest falling index. Else Evt=UNCHANGE.
//  - Multiple rises in one cycle: lowest index captured, others dropped, Multi_Err <= 1.
//  - Capture on Evt=UP and !Code_Full: Code <= {Code[..-DIGIT_W], Evt_Idx}; Code_Cnt++.
//    On the cycle Code_Cnt reaches CODE_DEPTH: Code_Full=1, Code_Vld=1 for one cycle.
//  - Full: further UP events still update Evt/Evt_Idx but Code/Code_Cnt frozen until CLR.
//  - CLR: next edge Code=0, Code_Cnt=0, Code_Full=0, Multi_Err=0.
//    CLR wins over a simultaneous capture (that digit is lost). Evt/SW_State unaffected.
//  - Latency, no debounce: SW edge -> Evt/Code updated 3 CLK later (2 sync + 1 capture).
//  - Reset mid-capture: async clear of all state; partial code discarded; re-arm as above.
// CONFIGURATION
//  SWITCH_DEBOUNCE_EN defined: per-bit counter after sync. hist/SW_State change only after
//    the synced bit differs from hist for DEB_CYCLES consecutive cycles.
//    A glitch shorter than that resets the counter, no event.
//    Latency = 2 + DEB_CYCLES + 1 cycles.
//  Not defined: no counters, DEB_CYCLES ignored, latency 3; every synced change is an event.
// STRUCTURE
//  switch_pkg: localparams EVT_UP=2'd1, EVT_DOWN=2'd0, EVT_UNCHANGE=2'd2, SYNC_STAGES=2,
//    ARM_CYCLES=3. Shared with code-compare logic.
//  Sub-module switch_debounce (one bit, DEB_CYCLES param), instantiated SW_N times in a
//    generate loop under the macro.
//  Priority encoder and digit shift register stay inline.
// TESTING
//  1 Reset with SW=10'h001 held; release -> no UP event; Evt=UNCHANGE, Code_Cnt=0.
//  2 Raise SW[3],[7],[0],[9] one at a time, 10 cycles apart ->
//    Code=16'h3709, Code_Vld pulses once, Code_Full=1.
//  3 When full, raise SW[5] -> Evt=UP, Evt_Idx=5, Code stays 16'h3709.
//    Pulse CLR -> Code=0, Code_Cnt=0.
//  4 Raise SW[2] and SW[6] same cycle -> digit 2 captured, Multi_Err=1.
//    Drop SW[2] -> Evt=DOWN, Evt_Idx=2.
//  5 CLR asserted same cycle as capture of SW[4] -> Code_Cnt=0, digit lost.
//    Async RST_N low with 2 digits held -> all outputs 0 immediately.
//  6 SWITCH_DEBOUNCE_EN, DEB_CYCLES=16: 5-cycle pulse on SW[1] -> no event.
//    SW[1] held 20 cycles -> Evt=UP exactly 19 cycles after the edge.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch front-end constants: event encodings, sync depth and arm delay.
// Also consumed by the downstream code-compare logic.
package switch_pkg;

  localparam logic [1:0] EVT_DOWN     = 2'd0;
  localparam logic [1:0] EVT_UP       = 2'd1;
  localparam logic [1:0] EVT_UNCHANGE = 2'd2;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ARM_CYCLES  = 3;

  typedef enum logic {
    StArming,
    StArmed
  } arm_state_e;

  // True when more than one bit of a switch vector is set.
  function automatic logic is_multi_hot(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One-bit debounce qualifier: flags acceptance once the synced level has
// disagreed with the committed history for DEB_CYCLES consecutive cycles.
module switch_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  input  logic i_hist,
  output logic o_accept
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Any cycle where sync agrees with history restarts the stability window.
  always_comb begin
    w_cnt_nxt = '0;
    o_accept  = 1'b0;
    if (i_sync != i_hist) begin
      if (r_cnt == CNT_W'(DEB_CYCLES)) begin
        o_accept = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/switch_code_capture.sv
// Switch front-end: synchronise, classify UP/DOWN/UNCHANGE, capture rising indices as code digits.
// Define SWITCH_DEBOUNCE_EN to insert a per-bit switch_debounce stage after the synchroniser.
module switch_code_capture
  import switch_pkg::*;
#(
  parameter int unsigned SW_N       = 10,
  parameter int unsigned CODE_DEPTH = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [SW_N-1:0]                    SW,
  input  logic                               CLR,
  output logic [SW_N-1:0]                    SW_State,
  output logic [1:0]                         Evt,
  output logic [DIGIT_W-1:0]                 Evt_Idx,
  output logic [CODE_DEPTH*DIGIT_W-1:0]      Code,
  output logic [$clog2(CODE_DEPTH+1)-1:0]    Code_Cnt,
  output logic                               Code_Full,
  output logic                               Code_Vld,
  output logic                               Multi_Err
);

  localparam int unsigned CODE_W = CODE_DEPTH * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(CODE_DEPTH + 1);
  localparam int unsigned ARM_W  = $clog2(ARM_CYCLES + 1);

  if (SW_N < 2 || SW_N > 16 || CODE_DEPTH < 1 || CODE_DEPTH > 8 ||
      DIGIT_W < $clog2(SW_N) || DEB_CYCLES < 1) begin : g_cfg_err
    $error("switch_code_capture: unsupported parameter combination");
  end

  // Input synchroniser
  logic [SW_N-1:0] r_sync [SYNC_STAGES];
  logic [SW_N-1:0] w_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= SW;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Arm sequencer: edge detection stays off while the sync chain refills after reset.
  arm_state_e       r_arm_state;
  arm_state_e       w_arm_state_nxt;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [ARM_W-1:0] w_arm_cnt_nxt;
  logic             w_armed;

  always_comb begin
    w_arm_state_nxt = r_arm_state;
    w_arm_cnt_nxt   = r_arm_cnt;
    w_armed         = 1'b0;
    unique case (r_arm_state)
      StArming: begin
        if (r_arm_cnt == ARM_W'(ARM_CYCLES - 1)) begin
          w_arm_state_nxt = StArmed;
        end else begin
          w_arm_cnt_nxt = r_arm_cnt + ARM_W'(1);
        end
      end
      StArmed: begin
        w_armed = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_arm_state <= StArming;
      r_arm_cnt   <= '0;
    end else begin
      r_arm_state <= w_arm_state_nxt;
      r_arm_cnt   <= w_arm_cnt_nxt;
    end
  end

  // Level that history should adopt this cycle when armed.
  logic [SW_N-1:0] r_hist;
  logic [SW_N-1:0] w_target;

`ifdef SWITCH_DEBOUNCE_EN
  logic [SW_N-1:0] w_accept;

  for (genvar g = 0; g < SW_N; g++) begin : g_deb
    switch_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .i_clk    (CLK),
      .i_rst_n  (RST_N),
      .i_sync   (w_sync[g]),
      .i_hist   (r_hist[g]),
      .o_accept (w_accept[g])
    );
  end

  assign w_target = (w_accept & w_sync) | (~w_accept & r_hist);
`else
  assign w_target = w_sync;
`endif

  logic [SW_N-1:0] w_rise;
  logic [SW_N-1:0] w_fall;
  logic            w_multi;

  assign w_rise  = w_armed ? (w_target & ~r_hist) : '0;
  assign w_fall  = w_armed ? (~w_target & r_hist) : '0;
  assign w_multi = is_multi_hot(16'(w_rise));

  // Lowest-index priority encoders and event classification
  logic [DIGIT_W-1:0] w_rise_idx;
  logic [DIGIT_W-1:0] w_fall_idx;
  logic [1:0]         w_evt;
  logic [DIGIT_W-1:0] w_idx;

  always_comb begin
    w_rise_idx = '0;
    w_fall_idx = '0;
    w_evt      = EVT_UNCHANGE;
    w_idx      = '0;
    for (int i = SW_N - 1; i >= 0; i--) begin
      if (w_rise[i]) w_rise_idx = DIGIT_W'(i);
      if (w_fall[i]) w_fall_idx = DIGIT_W'(i);
    end
    if (|w_rise) begin
      w_evt = EVT_UP;
      w_idx = w_rise_idx;
    end else if (|w_fall) begin
      w_evt = EVT_DOWN;
      w_idx = w_fall_idx;
    end
  end

  // Digit shift register; CLR takes priority over a same-cycle capture.
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [CNT_W-1:0]  r_code_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_code_vld;
  logic              w_vld_nxt;
  logic              r_multi_err;
  logic              w_multi_nxt;
  logic              w_full;
  logic              w_capture;
  logic [1:0]        r_evt;
  logic [DIGIT_W-1:0] r_evt_idx;

  assign w_full    = (r_code_cnt == CNT_W'(CODE_DEPTH));
  assign w_capture = (w_evt == EVT_UP) && !w_full;

  always_comb begin
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_code_cnt;
    w_vld_nxt   = 1'b0;
    w_multi_nxt = r_multi_err;
    if (CLR) begin
      w_code_nxt  = '0;
      w_cnt_nxt   = '0;
      w_multi_nxt = 1'b0;
    end else begin
      if (w_capture) begin
        w_code_nxt = (r_code << DIGIT_W) | CODE_W'(w_idx);
        w_cnt_nxt  = r_code_cnt + CNT_W'(1);
        w_vld_nxt  = (w_cnt_nxt == CNT_W'(CODE_DEPTH));
      end
      if (w_multi) begin
        w_multi_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hist      <= '0;
      r_evt       <= EVT_UNCHANGE;
      r_evt_idx   <= '0;
      r_code      <= '0;
      r_code_cnt  <= '0;
      r_code_vld  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_hist      <= w_armed ? w_target : w_sync;
      r_evt       <= w_evt;
      r_evt_idx   <= w_idx;
      r_code      <= w_code_nxt;
      r_code_cnt  <= w_cnt_nxt;
      r_code_vld  <= w_vld_nxt;
      r_multi_err <= w_multi_nxt;
    end
  end

  assign SW_State  = r_hist;
  assign Evt       = r_evt;
  assign Evt_Idx   = r_evt_idx;
  assign Code      = r_code;
  assign Code_Cnt  = r_code_cnt;
  assign Code_Full = w_full;
  assign Code_Vld  = r_code_vld;
  assign Multi_Err = r_multi_err;

endmodule
